pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central hazard sequencer for the 5-stage pipeline. Compares the instruction in ID against the instruction in EX and drives the stall and flush controls for PC, IF/ID and ID/EX. A small FSM holds multi-cycle load-use stalls and multi-cycle control-flush windows, and gives control hazards priority over data hazards. Also keeps saturating stall/flush event counters for performance debug.

Parameters:
LOAD_USE_STALL, 1, cycles of stall per load-use hazard (legal 1..7)
FLUSH_CYCLES, 1, cycles of ID/EX and IF/ID flush per taken redirect (legal 1..3)
LOAD_SEL, 2'b01, EXRegisterFileWriteSelect encoding that marks a load (DRAM to register file)

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  reset, synchronous, active-low
IDReadRegister1  in  5  rs1 index of the ID instruction
IDReadRegister1Used  in  1  ID instruction reads rs1
IDReadRegister2  in  5  rs2 index of the ID instruction
IDReadRegister2Used  in  1  ID instruction reads rs2
EXWriteRegister  in  5  rd of the EX instruction
EXRegisterFileWriteEnable  in  1  EX instruction writes the register file
EXRegisterFileWriteSelect  in  2  EX write-back source select
EXBranchTaken  in  1  EX resolved a taken branch or jump (redirect)
CounterClear  in  1  synchronous clear of both event counters
PcStall  out  1  hold PC
IFIDStall  out  1  hold IF/ID register
IFIDFlush  out  1  zero IF/ID register
DataHazard  out  1  bubble into ID/EX (load-use)
ControlHazard  out  1  flush ID/EX (redirect)
StallCount  out  32  cycles with DataHazard=1
FlushCount  out  32  cycles with ControlHazard=1

Behaviour:
- Hazard outputs are Mealy: combinational from state, cnt and current inputs, same cycle as detection. Downstream registers act on the next clk edge.
- Definition: lu_hit = EXRegisterFileWriteEnable & (EXRegisterFileWriteSelect==LOAD_SEL) & EXWriteRegister!=0 & ((IDReadRegister1Used & IDReadRegister1==EXWriteRegister) | (IDReadRegister2Used & IDReadRegister2==EXWriteRegister)).
- State: 3-bit cnt. FSM states RUN, STALL, FLUSH.
- RUN:
  - If EXBranchTaken: ControlHazard=1, IFIDFlush=1, DataHazard=0, PcStall=0, IFIDStall=0. If FLUSH_CYCLES>1, go FLUSH with cnt=FLUSH_CYCLES-1.
  - Else if lu_hit: DataHazard=1, PcStall=1, IFIDStall=1. If LOAD_USE_STALL>1, go STALL with cnt=LOAD_USE_STALL-1.
  - Else: all hazard outputs 0.
- STALL: DataHazard=PcStall=IFIDStall=1 regardless of lu_hit. cnt decrements each cycle; when cnt==1 the next state is RUN. EXBranchTaken in STALL takes priority: outputs as in the RUN branch case, go FLUSH/RUN exactly as from RUN, and the stall is abandoned.
- FLUSH: ControlHazard=IFIDFlush=1; all stall outputs 0 and lu_hit ignored. cnt decrements; at cnt==1 the next state is RUN. EXBranchTaken in FLUSH reloads cnt=FLUSH_CYCLES-1 (or returns to RUN if FLUSH_CYCLES==1).
- Invariants: IFIDStall and IFIDFlush are never 1 together. ControlHazard and DataHazard are never 1 together.
- Counters:
  - +1 on each clk with DataHazard (StallCount) or ControlHazard (FlushCount).
  - Saturate at 32'hFFFFFFFF.
  - CounterClear wins over increment.
- Reset, rst_n low at a clk edge:
  - state=RUN, cnt=0, StallCount=0, FlushCount=0.
  - While rst_n is low, all hazard outputs are forced to 0, also combinationally.
  - Reset mid-STALL or mid-FLUSH aborts the window; the first cycle after release is in RUN.

Test Plan:
- Load-use, LOAD_USE_STALL=1: EX lw x5 (we=1, sel=LOAD_SEL, rd=5), ID add rs1=5 used -> DataHazard/PcStall/IFIDStall=1 for exactly 1 cycle, StallCount 0->1, then RUN.
- Same stimulus with rd=0, or with rs1Used=0 and rs2=5 unused, or sel!=LOAD_SEL -> no hazard output asserted, StallCount unchanged.
- LOAD_USE_STALL=3, load-use then inputs cleared -> DataHazard high 3 consecutive cycles, StallCount=3; EXBranchTaken on 2nd cycle -> cycle 2 shows ControlHazard=1, DataHazard=0, no 3rd stall cycle.
- FLUSH_CYCLES=2, EXBranchTaken 1 cycle with simultaneous lu_hit -> ControlHazard=IFIDFlush=1 for 2 cycles, DataHazard=0 throughout, FlushCount=2.
- rst_n low for 1 edge in mid-STALL (LOAD_USE_STALL=5, cycle 2) -> outputs 0 while low; next cycle in RUN with cnt=0 and both counters 0.
- Preload StallCount to 32'hFFFFFFFE via forced stalls, then 3 hazard cycles -> holds 32'hFFFFFFFF; CounterClear together with a hazard cycle -> StallCount=0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard sequencer for the 5-stage pipeline: detects load-use hazards between ID and EX,
// holds multi-cycle stall / flush windows, and counts stall and flush cycles for debug.
module pipeline_hazard_ctrl #(
    parameter int unsigned LOAD_USE_STALL = 1,
    parameter int unsigned FLUSH_CYCLES   = 1,
    parameter logic [1:0]  LOAD_SEL       = 2'b01
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  IDReadRegister1,
    input  logic        IDReadRegister1Used,
    input  logic [4:0]  IDReadRegister2,
    input  logic        IDReadRegister2Used,
    input  logic [4:0]  EXWriteRegister,
    input  logic        EXRegisterFileWriteEnable,
    input  logic [1:0]  EXRegisterFileWriteSelect,
    input  logic        EXBranchTaken,
    input  logic        CounterClear,
    output logic        PcStall,
    output logic        IFIDStall,
    output logic        IFIDFlush,
    output logic        DataHazard,
    output logic        ControlHazard,
    output logic [31:0] StallCount,
    output logic [31:0] FlushCount
);

    // The detection cycle is counted as the first window cycle, so reload with N-1.
    localparam logic [2:0] StallReload = 3'(LOAD_USE_STALL - 1);
    localparam logic [2:0] FlushReload = 3'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {StRun, StStall, StFlush} state_e;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        lu_hit;
    logic        data_hz;
    logic        ctrl_hz;
    logic [31:0] stall_cnt_q, flush_cnt_q;
    logic [31:0] stall_cnt_d, flush_cnt_d;

    assign lu_hit = EXRegisterFileWriteEnable &&
                    (EXRegisterFileWriteSelect == LOAD_SEL) &&
                    (EXWriteRegister != 5'd0) &&
                    ((IDReadRegister1Used && (IDReadRegister1 == EXWriteRegister)) ||
                     (IDReadRegister2Used && (IDReadRegister2 == EXWriteRegister)));

    // Mealy hazard decode; a redirect always beats a data hazard, reset masks everything.
    always_comb begin
        ctrl_hz = 1'b0;
        data_hz = 1'b0;
        if (rst_n) begin
            if (EXBranchTaken || (state_q == StFlush)) begin
                ctrl_hz = 1'b1;
            end else if ((state_q == StStall) || lu_hit) begin
                data_hz = 1'b1;
            end
        end
    end

    assign PcStall       = data_hz;
    assign IFIDStall     = data_hz;
    assign DataHazard    = data_hz;
    assign IFIDFlush     = ctrl_hz;
    assign ControlHazard = ctrl_hz;

    // Window sequencing: a redirect (re)opens the flush window from any state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (EXBranchTaken) begin
            if (FLUSH_CYCLES > 1) begin
                state_d = StFlush;
                cnt_d   = FlushReload;
            end else begin
                state_d = StRun;
                cnt_d   = 3'd0;
            end
        end else begin
            unique case (state_q)
                StRun: begin
                    if (lu_hit && (LOAD_USE_STALL > 1)) begin
                        state_d = StStall;
                        cnt_d   = StallReload;
                    end
                end
                StStall, StFlush: begin
                    if (cnt_q <= 3'd1) begin
                        state_d = StRun;
                        cnt_d   = 3'd0;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
                default: begin
                    state_d = StRun;
                    cnt_d   = 3'd0;
                end
            endcase
        end
    end

    // Saturating event counters; clear has priority over increment.
    assign stall_cnt_d = CounterClear ? 32'd0 :
                         (data_hz && (stall_cnt_q != 32'hFFFF_FFFF)) ? stall_cnt_q + 32'd1 :
                         stall_cnt_q;
    assign flush_cnt_d = CounterClear ? 32'd0 :
                         (ctrl_hz && (flush_cnt_q != 32'hFFFF_FFFF)) ? flush_cnt_q + 32'd1 :
                         flush_cnt_q;

    assign StallCount = stall_cnt_q;
    assign FlushCount = flush_cnt_q;

    // State, window counter and event counters with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StRun;
            cnt_q       <= 3'd0;
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: four instances with different window lengths share one
// stimulus stream; a remaining-cycles model checks every output on every cycle.
module tb_pipeline_hazard_ctrl;

    localparam int N = 4;
    localparam int unsigned LUS [N] = '{1, 3, 1, 5};
    localparam int unsigned FC  [N] = '{1, 1, 2, 3};

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rs1, rs2, rd;
    logic       rs1_used, rs2_used, we, br, clr;
    logic [1:0] sel;

    logic        pc_stall   [N];
    logic        ifid_stall [N];
    logic        ifid_flush [N];
    logic        data_hz    [N];
    logic        ctrl_hz    [N];
    logic [31:0] stall_cnt  [N];
    logic [31:0] flush_cnt  [N];

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < N; g++) begin : gen_dut
            pipeline_hazard_ctrl #(
                .LOAD_USE_STALL (LUS[g]),
                .FLUSH_CYCLES   (FC[g]),
                .LOAD_SEL       (2'b01)
            ) u_dut (
                .clk                       (clk),
                .rst_n                     (rst_n),
                .IDReadRegister1           (rs1),
                .IDReadRegister1Used       (rs1_used),
                .IDReadRegister2           (rs2),
                .IDReadRegister2Used       (rs2_used),
                .EXWriteRegister           (rd),
                .EXRegisterFileWriteEnable (we),
                .EXRegisterFileWriteSelect (sel),
                .EXBranchTaken             (br),
                .CounterClear              (clr),
                .PcStall                   (pc_stall[g]),
                .IFIDStall                 (ifid_stall[g]),
                .IFIDFlush                 (ifid_flush[g]),
                .DataHazard                (data_hz[g]),
                .ControlHazard             (ctrl_hz[g]),
                .StallCount                (stall_cnt[g]),
                .FlushCount                (flush_cnt[g])
            );
        end
    endgenerate

    int pass_cnt = 0;
    int total    = 0;
    bit checking = 1'b0;
    bit preload  = 1'b0;

    // Model: extra stall / flush cycles still owed after the current one, plus counts.
    int          stall_rem [N];
    int          flush_rem [N];
    int          stall_rem_n [N];
    int          flush_rem_n [N];
    logic [31:0] m_stall [N];
    logic [31:0] m_flush [N];
    logic [31:0] m_stall_n [N];
    logic [31:0] m_flush_n [N];

    task automatic chk(input string name, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s inst%0d: got %h, expected %h", name, inst, act, exp);
    endtask

    // Compare on the falling edge and work out the model's next state.
    always @(negedge clk) begin
        logic lu;
        logic e_ctrl, e_data;
        lu = we && (sel == 2'b01) && (rd != 5'd0) &&
             ((rs1_used && rs1 == rd) || (rs2_used && rs2 == rd));
        for (int i = 0; i < N; i++) begin
            e_ctrl = 1'b0;
            e_data = 1'b0;
            if (rst_n) begin
                if (br || flush_rem[i] > 0) e_ctrl = 1'b1;
                else if (stall_rem[i] > 0 || lu) e_data = 1'b1;
            end
            if (checking) begin
                chk("PcStall",       i, {31'd0, pc_stall[i]},   {31'd0, e_data});
                chk("IFIDStall",     i, {31'd0, ifid_stall[i]}, {31'd0, e_data});
                chk("DataHazard",    i, {31'd0, data_hz[i]},    {31'd0, e_data});
                chk("IFIDFlush",     i, {31'd0, ifid_flush[i]}, {31'd0, e_ctrl});
                chk("ControlHazard", i, {31'd0, ctrl_hz[i]},    {31'd0, e_ctrl});
                chk("StallCount",    i, stall_cnt[i], m_stall[i]);
                chk("FlushCount",    i, flush_cnt[i], m_flush[i]);
            end
            stall_rem_n[i] = stall_rem[i];
            flush_rem_n[i] = flush_rem[i];
            if (!rst_n) begin
                stall_rem_n[i] = 0;
                flush_rem_n[i] = 0;
                m_stall_n[i]   = 32'd0;
                m_flush_n[i]   = 32'd0;
            end else begin
                if (br) begin
                    flush_rem_n[i] = int'(FC[i]) - 1;
                    stall_rem_n[i] = 0;
                end else if (flush_rem[i] > 0) begin
                    flush_rem_n[i] = flush_rem[i] - 1;
                end else if (stall_rem[i] > 0) begin
                    stall_rem_n[i] = stall_rem[i] - 1;
                end else if (lu) begin
                    stall_rem_n[i] = int'(LUS[i]) - 1;
                end
                if (clr) begin
                    m_stall_n[i] = 32'd0;
                    m_flush_n[i] = 32'd0;
                end else begin
                    m_stall_n[i] = (e_data && m_stall[i] != 32'hFFFF_FFFF) ? m_stall[i] + 1 :
                                   m_stall[i];
                    m_flush_n[i] = (e_ctrl && m_flush[i] != 32'hFFFF_FFFF) ? m_flush[i] + 1 :
                                   m_flush[i];
                end
                if (preload && i == 0) m_stall_n[i] = 32'hFFFF_FFFE;
            end
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            stall_rem[i] = stall_rem_n[i];
            flush_rem[i] = flush_rem_n[i];
            m_stall[i]   = m_stall_n[i];
            m_flush[i]   = m_flush_n[i];
        end
    end

    task automatic drive(input logic [4:0] r1, input logic u1, input logic [4:0] r2,
                         input logic u2, input logic [4:0] wr, input logic wen,
                         input logic [1:0] ws, input logic b, input logic c);
        rs1 = r1; rs1_used = u1; rs2 = r2; rs2_used = u2;
        rd = wr; we = wen; sel = ws; br = b; clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0);
    endtask

    // lw x5 in EX, add reading x5 in ID.
    task automatic lu_cycle(input logic b, input logic c);
        drive(5'd5, 1'b1, 5'd7, 1'b1, 5'd5, 1'b1, 2'b01, b, c);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            stall_rem[i] = 0; flush_rem[i] = 0; m_stall[i] = 0; m_flush[i] = 0;
        end
        rst_n = 1'b0;
        rs1 = 0; rs2 = 0; rd = 0; rs1_used = 0; rs2_used = 0; we = 0; sel = 0; br = 0; clr = 0;
        @(posedge clk);
        #1;
        checking = 1'b1;
        idle(1);
        rst_n = 1'b1;
        chk("reset StallCount", 0, stall_cnt[0], 32'd0);
        chk("reset DataHazard", 0, {31'd0, data_hz[0]}, 32'd0);

        // Single load-use, then quiet: each instance stalls for its own window length.
        lu_cycle(1'b0, 1'b0);
        idle(6);
        chk("lu window StallCount", 0, stall_cnt[0], 32'd1);
        chk("lu window StallCount", 1, stall_cnt[1], 32'd3);
        chk("lu window StallCount", 3, stall_cnt[3], 32'd5);

        // Near misses: rd=x0, rs1 unused with rs2 not read, non-load write-back.
        do_reset();
        drive(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 2'b01, 1'b0, 1'b0);
        drive(5'd5, 1'b0, 5'd5, 1'b0, 5'd5, 1'b1, 2'b01, 1'b0, 1'b0);
        drive(5'd5, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 2'b10, 1'b0, 1'b0);
        chk("no hazard StallCount", 1, stall_cnt[1], 32'd0);

        // Redirect on the second stall cycle abandons the stall.
        do_reset();
        lu_cycle(1'b0, 1'b0);
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b1, 1'b0);
        idle(4);
        chk("abandon StallCount", 1, stall_cnt[1], 32'd1);
        chk("abandon FlushCount", 1, flush_cnt[1], 32'd1);
        chk("abandon FlushCount", 2, flush_cnt[2], 32'd2);

        // Redirect together with load-use: control wins for the whole flush window.
        do_reset();
        lu_cycle(1'b1, 1'b0);
        idle(4);
        chk("br+lu FlushCount", 2, flush_cnt[2], 32'd2);
        chk("br+lu StallCount", 2, stall_cnt[2], 32'd0);
        chk("br+lu FlushCount", 3, flush_cnt[3], 32'd3);

        // Reset on stall cycle 2 aborts the window.
        do_reset();
        lu_cycle(1'b0, 1'b0);
        rst_n = 1'b0;
        rs1_used = 1'b0; rs2_used = 1'b0; we = 1'b0;
        #2;
        chk("in-reset DataHazard", 3, {31'd0, data_hz[3]}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("post-reset DataHazard", 3, {31'd0, data_hz[3]}, 32'd0);
        chk("post-reset StallCount", 3, stall_cnt[3], 32'd0);
        chk("post-reset FlushCount", 3, flush_cnt[3], 32'd0);
        idle(2);

        // Saturation: preload instance 0 just below the top, then clear during a hazard.
        do_reset();
        force gen_dut[0].u_dut.stall_cnt_d = 32'hFFFF_FFFE;
        preload = 1'b1;
        idle(1);
        release gen_dut[0].u_dut.stall_cnt_d;
        preload = 1'b0;
        chk("preload StallCount", 0, stall_cnt[0], 32'hFFFF_FFFE);
        lu_cycle(1'b0, 1'b0);
        lu_cycle(1'b0, 1'b0);
        lu_cycle(1'b0, 1'b0);
        chk("saturated StallCount", 0, stall_cnt[0], 32'hFFFF_FFFF);
        lu_cycle(1'b0, 1'b1);
        chk("clear StallCount", 0, stall_cnt[0], 32'd0);
        idle(6);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
